// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target register block: FSM states and register-file size.
package i2c_target_pkg;

    localparam int NREGS = 16;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    // Register pointer advances modulo NREGS.
    function automatic logic [3:0] ptr_next(input logic [3:0] p);
        return p + 4'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the SCL/SDA pads and flags SCL edges plus START/STOP bus conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Flops reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_pad};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_pad};
            scl_d  <= scl_ff[SYNC_STAGES-1];
            sda_d  <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_ff[SYNC_STAGES-1];
    assign sda      = sda_ff[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & ~sda & sda_d;
    assign stop     = scl_s & scl_d & sda & ~sda_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing 16 x 8-bit registers with an auto-incrementing pointer and a local port.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [3:0] loc_addr,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_pulse_o,
    output logic [3:0] wr_idx_o,
    output logic       busy_o,
    output logic [3:0] dbg_state
);

    logic       sda, scl_rise, scl_fall, start, stop;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic [3:0] ptr, ptr_n, ptr_inc;
    logic       oe, oe_n;
    logic       rw, rw_n;
    logic       nack, nack_n;
    logic       busy, busy_n;
    logic       commit;
    logic       wr_pulse;
    logic [3:0] wr_idx;
    logic [7:0] regs [NREGS];

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .scl_pad  (scl_i),
        .sda_pad  (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign ptr_inc = ptr_next(ptr);

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            ptr      <= '0;
            oe       <= 1'b0;
            rw       <= 1'b0;
            nack     <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            ptr      <= ptr_n;
            oe       <= oe_n;
            rw       <= rw_n;
            nack     <= nack_n;
            busy     <= busy_n;
            wr_pulse <= commit;
            if (commit) wr_idx <= ptr;
        end
    end

    // Local write is applied after the I2C commit so it wins on an index collision.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (commit) regs[ptr] <= sh;
            if (loc_we) regs[loc_addr] <= loc_wdata;
        end
    end

    // sda_oe only changes on SCL falls (or START/STOP/reset release), keeping SDA stable while SCL is high.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        oe_n    = oe;
        rw_n    = rw;
        nack_n  = nack;
        busy_n  = busy;
        commit  = 1'b0;
        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        sh_n  = {sh[6:0], sda};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        if (state == ADDR) begin
                            if (sh[7:1] == I2C_ADDR) begin
                                state_n = ADDR_ACK;
                                oe_n    = 1'b1;
                                rw_n    = sh[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end else if (state == PTR) begin
                            state_n = PTR_ACK;
                            oe_n    = 1'b1;
                            ptr_n   = sh[3:0];
                        end else begin
                            state_n = WDATA_ACK;
                            oe_n    = 1'b1;
                            commit  = 1'b1;
                            ptr_n   = ptr_inc;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_n = RDATA;
                            sh_n    = regs[ptr];
                            oe_n    = ~regs[ptr][7];
                        end else begin
                            state_n = PTR;
                            oe_n    = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_n = WDATA;
                        oe_n    = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        state_n = RDATA_ACK;
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                    end else if (scl_fall && cnt != 4'd0) begin
                        sh_n = {sh[6:0], 1'b0};
                        oe_n = ~sh[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        nack_n = sda;
                    end else if (scl_fall) begin
                        if (nack) begin
                            state_n = IGNORE;
                        end else begin
                            state_n = RDATA;
                            ptr_n   = ptr_inc;
                            sh_n    = regs[ptr_inc];
                            oe_n    = ~regs[ptr_inc][7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe_o   = oe;
    assign loc_rdata  = regs[loc_addr];
    assign wr_pulse_o = wr_pulse;
    assign wr_idx_o   = wr_idx;
    assign busy_o     = busy;
    assign dbg_state  = state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-file reference model, commit monitor.
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int         SS    = 2;
    localparam logic [6:0] ADDR7 = 7'h48;

    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe_o;
    logic [3:0] loc_addr = '0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_wdata = '0;
    logic [7:0] loc_rdata;
    logic       wr_pulse_o;
    logic [3:0] wr_idx_o;
    logic       busy_o;
    logic [3:0] dbg_state;

    int total = 0;
    int passed = 0;

    // Reference model: register file and pointer.
    logic [7:0] mem [16];
    int         mptr = 0;
    logic [3:0] exp_q [$];
    logic [7:0] tx_q [$];

    // Monitor-owned observations.
    int         pulse_cnt = 0;
    int         oe_cnt = 0;
    logic [3:0] got_idx [256];

    assign sda_line = sda_m & ~sda_oe_o;

    i2c_target_regs #(.I2C_ADDR(ADDR7), .SYNC_STAGES(SS)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe_o   (sda_oe_o),
        .loc_addr   (loc_addr),
        .loc_we     (loc_we),
        .loc_wdata  (loc_wdata),
        .loc_rdata  (loc_rdata),
        .wr_pulse_o (wr_pulse_o),
        .wr_idx_o   (wr_idx_o),
        .busy_o     (busy_o),
        .dbg_state  (dbg_state)
    );

    always #5 wb_clk = ~wb_clk;

    always @(negedge wb_clk) begin
        if (sda_oe_o) oe_cnt++;
        if (wr_pulse_o) begin
            got_idx[pulse_cnt & 255] = wr_idx_o;
            pulse_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic bit_cycle(input logic b, output logic line);
        sda_m = b;
        wait_clks(4);
        scl_m = 1'b1;
        wait_clks(4);
        line = sda_line;
        wait_clks(4);
        scl_m = 1'b0;
        wait_clks(4);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clks(4);
        scl_m = 1'b1;
        wait_clks(8);
        sda_m = 1'b0;
        wait_clks(8);
        scl_m = 1'b0;
        wait_clks(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clks(4);
        scl_m = 1'b1;
        wait_clks(8);
        sda_m = 1'b1;
        wait_clks(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], l);
        bit_cycle(1'b1, l);
        ack = ~l;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, l);
            d[i] = l;
        end
        bit_cycle(~master_ack, l);
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge wb_clk);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        @(negedge wb_clk);
        loc_we = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a;
        #1;
        d = loc_rdata;
    endtask

    // Full write transaction: pointer byte then every byte in tx_q; returns missing ACKs.
    task automatic do_write(input logic [7:0] p, output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        write_byte({ADDR7, 1'b0}, a);
        if (!a) nacks++;
        write_byte(p, a);
        if (!a) nacks++;
        foreach (tx_q[i]) begin
            write_byte(tx_q[i], a);
            if (!a) nacks++;
        end
        i2c_stop();
        wait_clks(4);
    endtask

    function automatic void model_write(input logic [7:0] p);
        mptr = int'(p[3:0]);
        foreach (tx_q[i]) begin
            mem[mptr] = tx_q[i];
            exp_q.push_back(4'(mptr));
            mptr = (mptr + 1) % 16;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mptr = 0;
    endfunction

    task automatic test_reset();
        logic [7:0] d;
        wb_rst = 1'b1;
        wait_clks(4);
        wb_rst = 1'b0;
        wait_clks(2);
        model_reset();
        total++; if (sda_oe_o !== 1'b0) $display("FAIL rst_oe got %b exp 0", sda_oe_o); else passed++;
        total++; if (wr_pulse_o !== 1'b0) $display("FAIL rst_pulse got %b exp 0", wr_pulse_o); else passed++;
        total++; if (wr_idx_o !== 4'd0) $display("FAIL rst_idx got %h exp 0", wr_idx_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else passed++;
        total++; if (dbg_state !== IDLE) $display("FAIL rst_state got %h exp %h", dbg_state, IDLE); else passed++;
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            total++; if (d !== mem[i]) $display("FAIL rst_reg%0d got %h exp %h", i, d, mem[i]); else passed++;
        end
    endtask

    task automatic check_commits(input string name, input int base);
        total++;
        if (pulse_cnt - base != exp_q.size())
            $display("FAIL %s_count got %0d exp %0d", name, pulse_cnt - base, exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            total++;
            if (got_idx[(base + i) & 255] !== exp_q[i])
                $display("FAIL %s_idx%0d got %h exp %h", name, i, got_idx[(base + i) & 255], exp_q[i]);
            else passed++;
        end
        exp_q.delete();
    endtask

    task automatic test_write_basic();
        logic a;
        logic [7:0] d;
        int base = pulse_cnt;
        i2c_start();
        write_byte({ADDR7, 1'b0}, a);
        total++; if (a !== 1'b1) $display("FAIL wb_addr_ack got %b exp 1", a); else passed++;
        total++; if (busy_o !== 1'b1) $display("FAIL wb_busy got %b exp 1", busy_o); else passed++;
        write_byte(8'h03, a);
        total++; if (a !== 1'b1) $display("FAIL wb_ptr_ack got %b exp 1", a); else passed++;
        write_byte(8'hA5, a);
        total++; if (a !== 1'b1) $display("FAIL wb_d0_ack got %b exp 1", a); else passed++;
        write_byte(8'h5A, a);
        total++; if (a !== 1'b1) $display("FAIL wb_d1_ack got %b exp 1", a); else passed++;
        i2c_stop();
        wait_clks(4);
        tx_q = '{8'hA5, 8'h5A};
        model_write(8'h03);
        total++; if (busy_o !== 1'b0) $display("FAIL wb_busy_stop got %b exp 0", busy_o); else passed++;
        peek(4'd3, d);
        total++; if (d !== mem[3]) $display("FAIL wb_reg3 got %h exp %h", d, mem[3]); else passed++;
        peek(4'd4, d);
        total++; if (d !== mem[4]) $display("FAIL wb_reg4 got %h exp %h", d, mem[4]); else passed++;
        check_commits("wb", base);
    endtask

    task automatic test_wrap();
        int nacks;
        logic [7:0] d;
        int base = pulse_cnt;
        tx_q = '{8'h11, 8'h22};
        do_write(8'h0F, nacks);
        model_write(8'h0F);
        total++; if (nacks != 0) $display("FAIL wrap_nacks got %0d exp 0", nacks); else passed++;
        peek(4'd15, d);
        total++; if (d !== mem[15]) $display("FAIL wrap_reg15 got %h exp %h", d, mem[15]); else passed++;
        peek(4'd0, d);
        total++; if (d !== mem[0]) $display("FAIL wrap_reg0 got %h exp %h", d, mem[0]); else passed++;
        check_commits("wrap", base);
    endtask

    task automatic test_read_nack();
        logic a;
        logic [7:0] d;
        local_write(4'd2, 8'hC3);
        mem[2] = 8'hC3;
        i2c_start();
        write_byte({ADDR7, 1'b0}, a);
        write_byte(8'h02, a);
        total++; if (a !== 1'b1) $display("FAIL rn_ptr_ack got %b exp 1", a); else passed++;
        i2c_start();
        write_byte({ADDR7, 1'b1}, a);
        total++; if (a !== 1'b1) $display("FAIL rn_addr_ack got %b exp 1", a); else passed++;
        mptr = 2;
        read_byte(1'b0, d);
        total++; if (d !== mem[mptr]) $display("FAIL rn_data got %h exp %h", d, mem[mptr]); else passed++;
        wait_clks(4);
        total++; if (dbg_state !== IGNORE) $display("FAIL rn_state got %h exp %h", dbg_state, IGNORE); else passed++;
        total++; if (sda_oe_o !== 1'b0) $display("FAIL rn_release got %b exp 0", sda_oe_o); else passed++;
        i2c_stop();
        wait_clks(4);
        total++; if (dbg_state !== IDLE) $display("FAIL rn_idle got %h exp %h", dbg_state, IDLE); else passed++;
    endtask

    task automatic test_wrong_addr();
        logic a;
        int oe0 = oe_cnt;
        int base = pulse_cnt;
        i2c_start();
        write_byte({ADDR7 + 7'd1, 1'b0}, a);
        total++; if (a !== 1'b0) $display("FAIL wa_addr_ack got %b exp 0", a); else passed++;
        write_byte(8'($urandom_range(0, 255)), a);
        total++; if (a !== 1'b0) $display("FAIL wa_b2_ack got %b exp 0", a); else passed++;
        total++; if (oe_cnt != oe0) $display("FAIL wa_oe got %0d exp 0", oe_cnt - oe0); else passed++;
        i2c_stop();
        wait_clks(4);
        total++; if (pulse_cnt != base) $display("FAIL wa_pulses got %0d exp 0", pulse_cnt - base); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL wa_busy got %b exp 0", busy_o); else passed++;
    endtask

    task automatic test_random();
        int nacks, n, m, base;
        logic [7:0] p, d, e;
        logic a;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [3:0] la = 4'($urandom_range(0, 15));
                logic [7:0] lv = 8'($urandom_range(0, 255));
                local_write(la, lv);
                mem[la] = lv;
            end
            base = pulse_cnt;
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
            do_write(p, nacks);
            model_write(p);
            total++; if (nacks != 0) $display("FAIL rnd%0d_wnacks got %0d exp 0", it, nacks); else passed++;
            check_commits("rnd", base);
            p = 8'($urandom_range(0, 255));
            m = $urandom_range(1, 3);
            nacks = 0;
            i2c_start();
            write_byte({ADDR7, 1'b0}, a);
            if (!a) nacks++;
            write_byte(p, a);
            if (!a) nacks++;
            i2c_start();
            write_byte({ADDR7, 1'b1}, a);
            if (!a) nacks++;
            mptr = int'(p[3:0]);
            for (int k = 0; k < m; k++) begin
                read_byte(k != m - 1, d);
                e = mem[mptr];
                total++; if (d !== e) $display("FAIL rnd%0d_rd%0d got %h exp %h", it, k, d, e); else passed++;
                if (k != m - 1) mptr = (mptr + 1) % 16;
            end
            i2c_stop();
            wait_clks(4);
            total++; if (nacks != 0) $display("FAIL rnd%0d_rnacks got %0d exp 0", it, nacks); else passed++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic a, l;
        logic [7:0] d;
        int nacks;
        int base;
        local_write(4'd7, 8'hE7);
        mem[7] = 8'hE7;
        i2c_start();
        write_byte({ADDR7, 1'b0}, a);
        write_byte(8'h07, a);
        i2c_start();
        write_byte({ADDR7, 1'b1}, a);
        total++; if (a !== 1'b1) $display("FAIL rmr_addr_ack got %b exp 1", a); else passed++;
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, l);
        sda_m = 1'b1;
        wait_clks(4);
        scl_m = 1'b1;
        wait_clks(2);
        total++; if (sda_oe_o !== ~mem[7][4]) $display("FAIL rmr_oe_bit4 got %b exp %b", sda_oe_o, ~mem[7][4]); else passed++;
        wb_rst = 1'b1;
        @(negedge wb_clk);
        total++; if (sda_oe_o !== 1'b0) $display("FAIL rmr_oe_rst got %b exp 0", sda_oe_o); else passed++;
        wb_rst = 1'b0;
        model_reset();
        wait_clks(2);
        total++; if (dbg_state !== IDLE) $display("FAIL rmr_state got %h exp %h", dbg_state, IDLE); else passed++;
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), d);
            total++; if (d !== mem[i]) $display("FAIL rmr_reg%0d got %h exp %h", i, d, mem[i]); else passed++;
        end
        wait_clks(2);
        scl_m = 1'b0;
        wait_clks(4);
        i2c_stop();
        wait_clks(4);
        base = pulse_cnt;
        tx_q = '{8'($urandom_range(0, 255))};
        do_write(8'h01, nacks);
        model_write(8'h01);
        total++; if (nacks != 0) $display("FAIL rmr_fresh_nacks got %0d exp 0", nacks); else passed++;
        peek(4'd1, d);
        total++; if (d !== mem[1]) $display("FAIL rmr_fresh_reg1 got %h exp %h", d, mem[1]); else passed++;
        check_commits("rmr", base);
    endtask

    task automatic test_collision();
        logic a, l;
        logic [7:0] d;
        logic [7:0] ib = 8'h88;
        int base = pulse_cnt;
        i2c_start();
        write_byte({ADDR7, 1'b0}, a);
        write_byte(8'h05, a);
        total++; if (a !== 1'b1) $display("FAIL col_ptr_ack got %b exp 1", a); else passed++;
        for (int i = 7; i >= 1; i--) bit_cycle(ib[i], l);
        sda_m = ib[0];
        wait_clks(4);
        scl_m = 1'b1;
        wait_clks(8);
        scl_m = 1'b0;
        // The commit lands SS+1 edges after the pad fall; align the local strobe with it.
        repeat (SS) @(negedge wb_clk);
        loc_addr  = 4'd5;
        loc_wdata = 8'h77;
        loc_we    = 1'b1;
        @(negedge wb_clk);
        loc_we = 1'b0;
        total++; if (wr_pulse_o !== 1'b1) $display("FAIL col_pulse got %b exp 1", wr_pulse_o); else passed++;
        wait_clks(2);
        bit_cycle(1'b1, l);
        total++; if (l !== 1'b0) $display("FAIL col_data_ack got %b exp 0", l); else passed++;
        i2c_stop();
        wait_clks(4);
        mem[5] = 8'h77;
        exp_q.push_back(4'd5);
        mptr = 6;
        peek(4'd5, d);
        total++; if (d !== mem[5]) $display("FAIL col_reg5 got %h exp %h", d, mem[5]); else passed++;
        check_commits("col", base);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_wrap();
        test_read_nack();
        test_wrong_addr();
        test_random();
        test_reset_mid_read();
        test_collision();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 Parameter I2C_ADDR, default 7'h48; 7-bit target address this block answers to.
REQ-002 Parameter SYNC_STAGES, default 2; number of input synchronizer flops on scl_i and sda_i (minimum 2).
REQ-003 wb_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst  in  1  reset, synchronous, active-high.
REQ-005 scl_i  in  1  I2C SCL pad input (asynchronous).
REQ-006 sda_i  in  1  I2C SDA pad input (asynchronous).
REQ-007 sda_oe_o  out  1  1 = pull SDA low; top level drives pad to 1'bz when 0.
REQ-008 loc_addr  in  4  local-side register index.
REQ-009 loc_we  in  1  local-side write strobe, one cycle.
REQ-010 loc_wdata  in  8  local-side write data.
REQ-011 loc_rdata  out  8  combinational read of reg[loc_addr].
REQ-012 wr_pulse_o  out  1  one-cycle pulse when an I2C data byte is committed to a register.
REQ-013 wr_idx_o  out  4  register index of the last I2C commit; valid with wr_pulse_o, held after.
REQ-014 busy_o  out  1  high from START that addresses this target until STOP.

Function
REQ-015 The block SHALL hold 16 x 8-bit registers plus a 4-bit pointer; pointer increments modulo 16 (15 -> 0).
REQ-016 SCL/SDA SHALL pass through SYNC_STAGES flops plus one delay flop for edge detection; total input latency SYNC_STAGES+1 cycles.
REQ-017 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high; both recognised in any state.
REQ-018 Data bits SHALL be sampled on synced SCL rising edge, MSB first; sda_oe_o SHALL change only on the cycle after a synced SCL falling edge.
REQ-019 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-020 START from any state -> ADDR with bit counter cleared (repeated START included); STOP from any state -> IDLE, sda_oe_o released.
REQ-021 ADDR: after 8 bits, address match -> ADDR_ACK (drive 0 for one SCL high period); mismatch -> IGNORE, no ACK.
REQ-022 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, shifting out reg[pointer].
REQ-023 PTR: 8th bit received -> PTR_ACK, pointer <= byte[3:0] (bits 7:4 ignored); then WDATA.
REQ-024 WDATA: 8th bit -> WDATA_ACK, reg[pointer] <= byte, wr_pulse_o=1 for one cycle, wr_idx_o <= pointer, pointer++.
REQ-025 RDATA: byte loaded at entry; sda_oe_o = ~bit; after 8th bit release SDA -> RDATA_ACK; master ACK(0) -> pointer++, load next byte, RDATA; NACK(1) -> IGNORE.
REQ-026 IGNORE SHALL never assert sda_oe_o; exits only on START or STOP.
REQ-027 Same-cycle local write and I2C commit to the same register: local write SHALL win; wr_pulse_o still asserts.
REQ-028 No clock stretching; correct operation required for wb_clk >= 16x SCL frequency.
REQ-029 Glitch on SDA while SCL high in mid-byte SHALL be treated as START/STOP per REQ-017 (no filtering beyond synchronizers).

Reset
REQ-030 On wb_rst: state IDLE, pointer 0, all registers 8'h00, sda_oe_o 0, wr_pulse_o 0, wr_idx_o 0, busy_o 0, synchronizer flops 1.
REQ-031 Reset mid-transaction SHALL release SDA in the next cycle; block resumes only at the next START.

Structure
REQ-032 State enumeration and NREGS=16 SHALL live in a shared package i2c_target_pkg.
REQ-033 Synchronizer + START/STOP/edge detect SHALL be a sub-module i2c_bus_sync, instantiated once per block.

Verification
REQ-034 Write 0x48/W, ptr 0x03, data 0xA5, 0x5A -> ACK on all 4 bytes, reg[3]=0xA5, reg[4]=0x5A, two wr_pulse_o with wr_idx_o 3 then 4.
REQ-035 Write ptr 0x0F, data 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap).
REQ-036 Local write reg[2]=0xC3; I2C W ptr 0x02, repeated START, R, master NACK -> SDA reads 0xC3, then released, state IGNORE until STOP.
REQ-037 Address 0x49 -> no ACK, sda_oe_o stays 0 through byte 2, no wr_pulse_o.
REQ-038 Assert wb_rst during RDATA bit 4 -> sda_oe_o 0 next cycle, all regs 0x00; fresh transaction afterward ACKs normally.
REQ-039 Local write and I2C commit to reg[5] same cycle (0x77 local, 0x88 I2C) -> reg[5]=0x77, wr_pulse_o asserted.
